// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : dmem_responder
// Brief    : Data-memory responder for the core's load/store port. Accepts one
//            valid/ready request, holds it for WAIT_CYCLES wait states, performs
//            a byte-enabled word access and returns the result over a
//            valid/ready response channel.
// Options  : DMEM_ALIGN_CHECK_EN - flag misaligned addresses with rsp_err and
//            suppress their array access.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int       c_idxW     = $clog2(DEPTH_WORDS);
  localparam bit [3:0] c_waitLoad = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } stateT;

  stateT             r_state;
  stateT             w_nextState;
  logic [3:0]        r_count;
  logic [3:0]        w_nextCount;
  logic              w_accept;
  logic              w_access;
  logic              w_misaligned;
  logic              w_doWrite;

  logic              r_write;
  logic [c_idxW-1:0] r_idx;
  logic [31:0]       r_wdata;
  logic [3:0]        r_be;

  // Array contents are deliberately not reset.
  logic [31:0]       r_mem [0:DEPTH_WORDS-1];

  // Upper address bits only alias; with the alignment check disabled the
  // byte offset is dropped as well.
  logic              w_unusedAddr;
  assign w_unusedAddr = ^{req_addr[31:c_idxW+2], req_addr[1:0]};

`ifdef DMEM_ALIGN_CHECK_EN
  logic [1:0]        r_offs;

  // Byte offset of the captured request, kept only for the alignment check.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)         r_offs <= 2'b00;
    else if (w_accept) r_offs <= req_addr[1:0];
  end

  assign w_misaligned = (r_offs != 2'b00);
`else
  assign w_misaligned = 1'b0;
`endif

  assign req_ready = (r_state == IDLE) && !reset;
  assign rsp_valid = (r_state == RESP);
  assign w_accept  = req_valid && (r_state == IDLE);
  assign w_doWrite = w_access && r_write && !w_misaligned;

  // State and wait-counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_count <= 4'd0;
    end else begin
      r_state <= w_nextState;
      r_count <= w_nextCount;
    end
  end

  // Next-state logic; the access fires on the edge that leaves WAIT.
  always_comb begin
    w_nextState = r_state;
    w_nextCount = r_count;
    w_access    = 1'b0;
    case (r_state)
      IDLE: begin
        if (req_valid) begin
          w_nextState = WAIT;
          w_nextCount = c_waitLoad;
        end
      end
      WAIT: begin
        if (r_count != 4'd0) begin
          w_nextCount = r_count - 4'd1;
        end else begin
          w_access    = 1'b1;
          w_nextState = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) w_nextState = IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  // Request capture; inputs are ignored outside IDLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_write <= 1'b0;
      r_idx   <= '0;
      r_wdata <= 32'd0;
      r_be    <= 4'd0;
    end else if (w_accept) begin
      r_write <= req_write;
      r_idx   <= req_addr[c_idxW+1:2];
      r_wdata <= req_wdata;
      r_be    <= req_be;
    end
  end

  // Response data/flag, loaded at the access edge and held through RESP.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
    end else if (w_access) begin
      rsp_rdata <= (r_write || w_misaligned) ? 32'd0 : r_mem[r_idx];
      rsp_err   <= w_misaligned;
    end
  end

  // Byte-lane store; reset forces IDLE asynchronously so no write can occur
  // while reset is held.
  always_ff @(posedge clk) begin
    if (w_doWrite) begin
      for (int i = 0; i < 4; i++) begin
        if (r_be[i]) r_mem[r_idx][8*i +: 8] <= r_wdata[8*i +: 8];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_responder
// Brief    : Directed, table-driven bench for dmem_responder (WAIT_CYCLES 2
//            and 0 instances, DEPTH_WORDS 256).
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;

  logic        reqValid = 1'b0;
  logic        reqWrite = 1'b0;
  logic [31:0] reqAddr  = 32'd0;
  logic [31:0] reqWdata = 32'd0;
  logic [3:0]  reqBe    = 4'd0;
  logic        rspReady = 1'b0;
  logic        reqReady;
  logic        rspValid;
  logic [31:0] rspRdata;
  logic        rspErr;

  logic        reqValid1 = 1'b0;
  logic        reqWrite1 = 1'b0;
  logic [31:0] reqAddr1  = 32'd0;
  logic [31:0] reqWdata1 = 32'd0;
  logic        reqReady1;
  logic        rspValid1;
  logic [31:0] rspRdata1;
  logic        rspErr1;

  int nChecks = 0;
  int nErr    = 0;
  int cyc     = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(2)) dut (
    .clk(clk), .reset(reset),
    .req_valid(reqValid), .req_ready(reqReady), .req_write(reqWrite),
    .req_addr(reqAddr), .req_wdata(reqWdata), .req_be(reqBe),
    .rsp_valid(rspValid), .rsp_ready(rspReady),
    .rsp_rdata(rspRdata), .rsp_err(rspErr)
  );

  dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0)) dut0w (
    .clk(clk), .reset(reset),
    .req_valid(reqValid1), .req_ready(reqReady1), .req_write(reqWrite1),
    .req_addr(reqAddr1), .req_wdata(reqWdata1), .req_be(4'hF),
    .rsp_valid(rspValid1), .rsp_ready(1'b1),
    .rsp_rdata(rspRdata1), .rsp_err(rspErr1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One transaction on the WAIT_CYCLES=2 instance. hold=0 raises rsp_ready
  // ahead of the response; otherwise the response is backpressured for hold
  // cycles while stability is checked.
  task automatic txn(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [3:0] be, input int hold,
                     output logic [31:0] rd, output logic err, output int lat);
    int t;
    @(negedge clk);
    t = 0;
    while (!reqReady && t < 20) begin @(negedge clk); t++; end
    chk("req_ready_before_accept", {31'd0, reqReady}, 32'd1);
    reqValid = 1'b1; reqWrite = wr; reqAddr = addr; reqWdata = wdata; reqBe = be;
    rspReady = (hold == 0);
    @(posedge clk);
    #1 reqValid = 1'b0;
    lat = 0;
    do begin
      @(posedge clk); #1; lat++;
    end while (!rspValid && lat < 50);
    rd  = rspRdata;
    err = rspErr;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      chk("hold_rsp_valid", {31'd0, rspValid}, 32'd1);
      chk("hold_rsp_rdata", rspRdata, rd);
      chk("hold_req_ready", {31'd0, reqReady}, 32'd0);
    end
    rspReady = 1'b1;
    @(posedge clk); #1;
    rspReady = 1'b0;
    chk("idle_after_handshake", {31'd0, reqReady}, 32'd1);
  endtask

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] expData;
    int          hold;
  } vecT;

  vecT vec[12];

  initial begin
    logic [31:0] rd;
    logic        err;
    int          lat;
    int          t;
    int          lastAcc;
    logic [31:0] a1 [6];
    logic [31:0] d1 [6];

    vec[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 32'h0000_0000, 0};
    vec[1]  = '{1'b0, 32'h0000_0010, 32'h0000_0000, 4'hF, 32'hDEAD_BEEF, 0};
    vec[2]  = '{1'b1, 32'h0000_0020, 32'h1122_3344, 4'hF, 32'h0000_0000, 0};
    vec[3]  = '{1'b1, 32'h0000_0020, 32'hAABB_CCDD, 4'h5, 32'h0000_0000, 0};
    vec[4]  = '{1'b0, 32'h0000_0020, 32'h0000_0000, 4'hF, 32'h11BB_33DD, 0};
    vec[5]  = '{1'b1, 32'h0000_0040, 32'hCAFE_F00D, 4'hF, 32'h0000_0000, 0};
    vec[6]  = '{1'b1, 32'h0000_0030, 32'h1234_5678, 4'hF, 32'h0000_0000, 0};
    vec[7]  = '{1'b1, 32'h0000_0060, 32'h0102_0304, 4'hF, 32'h0000_0000, 0};
    vec[8]  = '{1'b1, 32'h0000_0060, 32'hFFFF_FFFF, 4'h0, 32'h0000_0000, 0};
    vec[9]  = '{1'b0, 32'h0000_0060, 32'h0000_0000, 4'h0, 32'h0102_0304, 0};
    vec[10] = '{1'b0, 32'h0000_1010, 32'h0000_0000, 4'hF, 32'hDEAD_BEEF, 1};
    vec[11] = '{1'b1, 32'h0000_0050, 32'h55AA_55AA, 4'hF, 32'h0000_0000, 0};

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    chk("reset_req_ready", {31'd0, reqReady}, 32'd0);
    chk("reset_rsp_valid", {31'd0, rspValid}, 32'd0);
    chk("reset_rsp_rdata", rspRdata, 32'd0);
    chk("reset_rsp_err",   {31'd0, rspErr}, 32'd0);
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;
    chk("ready_after_reset", {31'd0, reqReady}, 32'd1);

    // Table-driven transactions.
    for (int i = 0; i < 12; i++) begin
      txn(vec[i].wr, vec[i].addr, vec[i].wdata, vec[i].be, vec[i].hold, rd, err, lat);
      chk($sformatf("vec%0d_rdata", i), rd, vec[i].expData);
      chk($sformatf("vec%0d_err", i), {31'd0, err}, 32'd0);
      chk($sformatf("vec%0d_latency", i), lat, 32'd3);
    end

    // Backpressured aliased load: 0x440 maps onto word 0x40.
    txn(1'b0, 32'h0000_0440, 32'd0, 4'hF, 5, rd, err, lat);
    chk("alias_load_rdata", rd, 32'hCAFE_F00D);
    chk("alias_load_latency", lat, 32'd3);

    // Reset one cycle after accepting a store to 0x30 drops the store.
    @(negedge clk);
    reqValid = 1'b1; reqWrite = 1'b1; reqAddr = 32'h30; reqWdata = 32'h0; reqBe = 4'hF;
    @(posedge clk);
    #1 reqValid = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    #1;
    chk("midrst_req_ready", {31'd0, reqReady}, 32'd0);
    chk("midrst_rsp_valid", {31'd0, rspValid}, 32'd0);
    chk("midrst_rsp_rdata", rspRdata, 32'd0);
    chk("midrst_rsp_err",   {31'd0, rspErr}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("midrst_hold_rsp_valid", {31'd0, rspValid}, 32'd0);
    @(negedge clk) reset = 1'b0;
    txn(1'b0, 32'h0000_0030, 32'd0, 4'hF, 0, rd, err, lat);
    chk("midrst_load_rdata", rd, 32'h1234_5678);

    // Misaligned store to 0x52, then load of 0x50.
    txn(1'b1, 32'h0000_0052, 32'hFFFF_FFFF, 4'hF, 0, rd, err, lat);
    chk("misalign_rdata", rd, 32'd0);
    chk("misalign_latency", lat, 32'd3);
`ifdef DMEM_ALIGN_CHECK_EN
    chk("misalign_err", {31'd0, err}, 32'd1);
    txn(1'b0, 32'h0000_0050, 32'd0, 4'hF, 0, rd, err, lat);
    chk("after_misalign_rdata", rd, 32'h55AA_55AA);
`else
    chk("misalign_err", {31'd0, err}, 32'd0);
    txn(1'b0, 32'h0000_0050, 32'd0, 4'hF, 0, rd, err, lat);
    chk("after_misalign_rdata", rd, 32'hFFFF_FFFF);
`endif
    chk("after_misalign_err", {31'd0, err}, 32'd0);

    // WAIT_CYCLES=0 instance with rsp_ready tied high: back-to-back
    // three stores then three loads, one every 3 cycles, 1-edge latency.
    a1[0] = 32'h0; a1[1] = 32'h4; a1[2] = 32'h8;
    a1[3] = 32'h4; a1[4] = 32'h0; a1[5] = 32'h8;
    d1[0] = 32'hA0A0_0001; d1[1] = 32'hB0B0_0002; d1[2] = 32'hC0C0_0003;
    d1[3] = 32'hB0B0_0002; d1[4] = 32'hA0A0_0001; d1[5] = 32'hC0C0_0003;
    lastAcc = 0;
    @(negedge clk);
    reqValid1 = 1'b1;
    for (int k = 0; k < 6; k++) begin
      reqWrite1 = (k < 3);
      reqAddr1  = a1[k];
      reqWdata1 = d1[k];
      t = 0;
      while (!reqReady1 && t < 20) begin @(negedge clk); t++; end
      chk($sformatf("w0_ready%0d", k), {31'd0, reqReady1}, 32'd1);
      if (k != 0) chk($sformatf("w0_interval%0d", k), cyc - lastAcc, 32'd3);
      lastAcc = cyc;
      @(posedge clk);
      @(posedge clk); #1;
      chk($sformatf("w0_rsp_valid%0d", k), {31'd0, rspValid1}, 32'd1);
      chk($sformatf("w0_rdata%0d", k), rspRdata1, (k < 3) ? 32'd0 : d1[k]);
      chk($sformatf("w0_err%0d", k), {31'd0, rspErr1}, 32'd0);
      @(negedge clk);
    end
    reqValid1 = 1'b0;

    $display("Result: errors=%0d of %0d checks", nErr, nChecks);
    $finish;
  end

endmodule
`default_nettype wire
